// File: rtl/nios_system_ack_handshake_ctrl.sv
// Request/acknowledge handshake controller with a small Avalon-style register slave.
// Optional request-release timeout is enabled by defining ACK_TIMEOUT_EN.
module nios_system_ack_handshake_ctrl #(
    parameter int PW_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        req_in,
    output logic        ack_out,
    output logic        irq
);
    // state    | meaning
    // IDLE     | waiting for a request rising edge
    // WAIT_SW  | request seen, waiting for software go
    // ACK_HOLD | ack driven, counting the pulse width
    // WAIT_REL | ack held until the request is released
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SW  = 2'd1,
        ACK_HOLD = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t              state;
    logic                req_m, req_s, req_d, armed;
    logic [1:0]          primed;
    logic [PW_WIDTH-1:0] pw, hold_cnt;
    logic                irq_en;
    logic [31:0]         tx_count;
    logic                wr_en, wr0, go, abort, req_rise, pending, done;
    logic                timeout_flag;
    logic                unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wr0       = wr_en && (address == 2'd0);
    assign go        = wr0 & writedata[0];
    assign abort     = wr0 & writedata[4];
    assign pending   = (state == WAIT_SW);
    assign req_rise  = armed & req_s & ~req_d;
    assign unused_wd = ^writedata;
    assign done      = ~req_s && ((state == WAIT_REL) ||
                       (state == ACK_HOLD && hold_cnt == PW_WIDTH'(1)));

`ifdef ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic [15:0]   to_count;
    logic          to_fire;

    assign to_fire = (state == WAIT_REL) && req_s && (to_cnt == TW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt       <= TW'(TIMEOUT_CYCLES);
            timeout_flag <= 1'b0;
            to_count     <= 16'd0;
        end else begin
            if (state != WAIT_REL)
                to_cnt <= TW'(TIMEOUT_CYCLES);
            else if (req_s && to_cnt != '0)
                to_cnt <= to_cnt - TW'(1);
            if (to_fire && !abort)
                timeout_flag <= 1'b1;
            else if (wr0 && writedata[3])
                timeout_flag <= 1'b0;
            if (wr_en && address == 2'd3)
                to_count <= 16'd0;
            else if (to_fire && !abort && to_count != 16'hFFFF)
                to_count <= to_count + 16'd1;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    // Armed only once the synchroniser has seen a real low, so a request
    // still high across reset release cannot masquerade as a new edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_m  <= 1'b0;
            req_s  <= 1'b0;
            req_d  <= 1'b0;
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            req_m  <= req_in;
            req_s  <= req_m;
            req_d  <= req_s;
            primed <= {primed[0], 1'b1};
            if (primed[1] && !req_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ack_out  <= 1'b0;
            hold_cnt <= '0;
        end else if (abort) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_rise) state <= WAIT_SW;
                WAIT_SW: if (go) begin
                    state    <= ACK_HOLD;
                    ack_out  <= 1'b1;
                    hold_cnt <= (pw == '0) ? PW_WIDTH'(1) : pw;
                end
                // Released request exits straight from the hold so ack is exactly N cycles.
                ACK_HOLD: if (hold_cnt == PW_WIDTH'(1)) begin
                    if (!req_s) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end else begin
                        state <= WAIT_REL;
                    end
                end else begin
                    hold_cnt <= hold_cnt - PW_WIDTH'(1);
                end
                WAIT_REL: begin
                    if (!req_s) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end
`ifdef ACK_TIMEOUT_EN
                    else if (to_fire) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            pw       <= PW_WIDTH'(4);
            tx_count <= 32'd0;
            irq      <= 1'b0;
        end else begin
            if (wr0)
                irq_en <= writedata[2];
            if (wr_en && address == 2'd1)
                pw <= writedata[PW_WIDTH-1:0];
            if (wr_en && address == 2'd2)
                tx_count <= 32'd0;
            else if (done && !abort)
                tx_count <= tx_count + 32'd1;
            irq <= irq_en & (pending | timeout_flag);
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: begin
                readdata[0]   = pending;
                readdata[1]   = ack_out;
                readdata[2]   = irq_en;
                readdata[3]   = timeout_flag;
                readdata[5:4] = state;
            end
            2'd1: readdata[PW_WIDTH-1:0] = pw;
            2'd2: readdata = tx_count;
            2'd3: begin
`ifdef ACK_TIMEOUT_EN
                readdata[15:0] = to_count;
`endif
            end
            default: readdata = 32'd0;
        endcase
    end
endmodule

// File: doc/nios_system_ack_handshake_ctrl.md
NIOS_SYSTEM_ACK_HANDSHAKE_CTRL -- requirements
Module: nios_system_ack_handshake_ctrl

Interface
REQ-001 SHALL have parameter PW_WIDTH, default 16, the bit width of the ack pulse-width register.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, the request-release timeout in clk cycles.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock; reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have address  input  2  register select.
REQ-005 SHALL have chipselect  input  1  slave select.
REQ-006 SHALL have write_n  input  1  active-low write strobe.
REQ-007 SHALL have writedata  input  32  write data.
REQ-008 SHALL have readdata  output  32  combinational read data, zero wait states.
REQ-009 SHALL have req_in  input  1  asynchronous external request.
REQ-010 SHALL have ack_out  output  1  registered external acknowledge.
REQ-011 SHALL have irq  output  1  level interrupt.

Function
REQ-012 SHALL synchronise req_in through 2 flops (req_s) and SHALL detect a rising edge (req_rise) from req_s and its 1-cycle delay.
REQ-013 SHALL implement the states IDLE=0, WAIT_SW=1, ACK_HOLD=2 and WAIT_REL=3.
REQ-014 In IDLE, req_rise SHALL move the FSM to WAIT_SW, 3 clk edges after req_in rises; a req_s level held high without an edge SHALL NOT trigger.
REQ-015 In WAIT_SW, a write to addr0 with bit0=1 SHALL move the FSM to ACK_HOLD and load the hold counter with the pulse width (0 treated as 1).
REQ-016 In ACK_HOLD, ack_out SHALL be high for exactly N cycles, then the FSM SHALL move to WAIT_REL.
REQ-017 In WAIT_REL, ack_out SHALL stay high; when req_s goes low, the FSM SHALL return to IDLE, ack_out SHALL fall on the same edge, and the transaction counter SHALL increment.
REQ-018 A write to addr0 with bit0=1 outside WAIT_SW SHALL be ignored.
REQ-019 A write to addr0 with bit4=1 (abort) SHALL force IDLE with ack_out low on the next edge from any state, with no count increment; abort SHALL win over a simultaneous bit0.
REQ-020 Addr0 read SHALL return: bit0 pending (state==WAIT_SW), bit1 ack_out, bit2 irq_en, bit3 timeout flag, bits[5:4] state, remaining bits 0.
REQ-021 Addr0 write SHALL load irq_en from bit2, and writing 1 to bit3 SHALL clear the timeout flag.
REQ-022 Addr1 SHALL read/write the pulse width in bits[PW_WIDTH-1:0]; a write during ACK_HOLD SHALL affect only the next transaction.
REQ-023 Addr2 SHALL read the 32-bit transaction count, which wraps 0xFFFFFFFF->0; any write SHALL clear it, and the clear SHALL win over a same-cycle increment.
REQ-024 Addr3 SHALL read the 16-bit saturating timeout count; any write SHALL clear it.
REQ-025 Writes SHALL be accepted when chipselect && ~write_n, and reads SHALL have no side effects.
REQ-026 irq SHALL be registered as irq_en & (pending | timeout_flag).

Reset
REQ-027 On reset_n low, the FSM SHALL go asynchronously to IDLE with ack_out=0, irq=0, irq_en=0, timeout flag=0, counters=0, pulse width=4 and synchroniser flops=0.
REQ-028 Reset asserted mid-transaction SHALL drop ack_out immediately; after release, a still-high req_in SHALL NOT start a transaction without a new rising edge.

Configuration
REQ-029 With ACK_TIMEOUT_EN defined, a WAIT_REL counter SHALL force IDLE after TIMEOUT_CYCLES cycles with req_s high, set the timeout flag, increment addr3, drop ack_out and not increment addr2.
REQ-030 Without ACK_TIMEOUT_EN, WAIT_REL SHALL wait indefinitely, addr3 and the timeout flag SHALL read 0, and no timeout logic SHALL be synthesised.

Verification
REQ-031 Pulse width 4, irq_en=1; raise req_in -> pending and irq high within 4 cycles; write addr0=0x1 -> ack_out high; drop req_in after 10 cycles -> ack_out falls 2-3 cycles later; addr2=1.
REQ-032 Pulse width 8; req_in pulses high for 3 cycles only -> ack_out high for exactly 8 cycles, then returns to IDLE; addr2=1.
REQ-033 ACK_TIMEOUT_EN, TIMEOUT_CYCLES=20; req_in held high -> ack_out drops, addr0 bit3=1, addr3=1, addr2=0, and no retrigger until req_in toggles.
REQ-034 In ACK_HOLD, write addr0=0x11 -> IDLE and ack_out low next edge; addr2 unchanged.
REQ-035 Preload addr2 to 0xFFFFFFFF via a back-door force, complete one transaction -> addr2=0; a write clearing addr2 on the completion cycle -> addr2=0.
REQ-036 Assert reset_n in WAIT_REL -> ack_out=0 immediately; release with req_in high -> state stays IDLE.
